// File: rtl/large_ram_pkg.sv
// large_ram_pkg: shared constants, access classification and bank sizing helper
// for the banked large_ram. Optional feature macro: LARGE_RAM_CLEAR_ON_RESET_EN.
package large_ram_pkg;

  localparam int NUM_BANKS          = 4;
  localparam int BANK_SEL_WIDTH     = 2;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  // Kind of access requested by the bus in the current cycle
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_READ  = 2'd2
  } access_e;

  // Word address width inside one bank
  function automatic int bank_addr_width(input int addr_width);
    return addr_width - BANK_SEL_WIDTH;
  endfunction

endpackage

// File: rtl/large_ram_bank.sv
// ram_bank: single-port RAM bank with registered read and its own chip select.
// With LARGE_RAM_CLEAR_ON_RESET_EN defined, reset zeroes every word; otherwise
// the array has no reset and maps to plain RAM.
module ram_bank
  import large_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BANK_AW    = bank_addr_width(DEFAULT_ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [BANK_AW-1:0]    addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** BANK_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef LARGE_RAM_CLEAR_ON_RESET_EN
  // Storage write, with whole-array clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (cs && we) begin
      mem[addr] <= wdata;
    end
  end
`else
  // Storage write; no reset so the array stays a plain RAM
  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem[addr] <= wdata;
    end
  end
`endif

  // Registered read port, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (cs && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/large_ram.sv
// large_ram: four-bank RAM behind a shared bidirectional data bus.
// Holds access classification, bank decode, read-data mux and tri-state driver.
// Optional feature macro: LARGE_RAM_CLEAR_ON_RESET_EN (clear all banks on reset).
module large_ram
  import large_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  chip_select_in,
  input  logic                  write_enable,
  input  logic                  output_enable
);

  localparam int BANK_AW = bank_addr_width(ADDR_WIDTH);

  access_e                   acc;
  logic [BANK_SEL_WIDTH-1:0] bank_sel;
  logic [BANK_AW-1:0]        bank_off;
  logic [BANK_SEL_WIDTH-1:0] sel_q;
  logic [NUM_BANKS-1:0]      bank_cs;
  logic [DATA_WIDTH-1:0]     bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0]     rd_q;
  logic                      drive;

  assign bank_sel = addr[ADDR_WIDTH-1:BANK_AW];
  assign bank_off = addr[BANK_AW-1:0];

  // Classify the access; write with output_enable high is ignored, reset blocks all
  always_comb begin
    acc = ACC_IDLE;
    if (!rst && chip_select_in) begin
      if (!write_enable) begin
        acc = ACC_READ;
      end else if (!output_enable) begin
        acc = ACC_WRITE;
      end
    end
  end

  // One-hot bank enable: exactly the addressed bank sees the access
  always_comb begin
    bank_cs = '0;
    if (acc != ACC_IDLE) begin
      bank_cs[bank_sel] = 1'b1;
    end
  end

  // Remember which bank the read register belongs to; reset picks bank 0, whose
  // read register is itself cleared, so rd_q reads as zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
    end else if (acc == ACC_READ) begin
      sel_q <= bank_sel;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .BANK_AW   (BANK_AW)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .cs   (bank_cs[b]),
      .we   (acc == ACC_WRITE),
      .addr (bank_off),
      .wdata(data),
      .rdata(bank_rdata[b])
    );
  end

  assign rd_q  = bank_rdata[sel_q];
  assign drive = !rst && chip_select_in && !write_enable && output_enable;
  assign data  = drive ? rd_q : 'z;

endmodule

// File: tb/tb_large_ram.sv
// tb_large_ram: randomized + directed scoreboard bench for large_ram.
// Inputs change on the falling edge; the monitor samples the bus 1 ns after each
// rising edge. Whenever the RAM must not drive, the bench drives a known value and
// expects to read exactly that value back, which exposes any unwanted drive.
module tb_large_ram;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          chip_select_in = 1'b0;
  logic          write_enable = 1'b0;
  logic          output_enable = 1'b0;
  logic [DW-1:0] tb_data = '0;
  logic          tb_en = 1'b1;
  wire  [DW-1:0] data;

  assign data = tb_en ? tb_data : 'z;

  large_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .data          (data),
    .chip_select_in(chip_select_in),
    .write_enable  (write_enable),
    .output_enable (output_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    bit            chk;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sbq[$];
  int unsigned   n_chk = 0;
  int unsigned   n_pass = 0;

  // Reference model: sparse word store plus read-register contents
  logic [DW-1:0] model_mem [int];
  bit            cleared = 1'b0;
  logic [DW-1:0] rdq_m = '0;
  bit            rdq_known = 1'b1;

  // One bus cycle: apply inputs, update model, queue the expected bus value
  task automatic cycle(input bit r, input bit cs, input bit we, input bit oe,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input string nm);
    exp_t e;
    bit   drv;
    @(negedge clk);
    rst = r; chip_select_in = cs; write_enable = we; output_enable = oe; addr = a;
    drv = !r && cs && !we && oe;
    tb_en = !drv;
    tb_data = we ? wd : '0;
    if (r) begin
      rdq_m = '0;
      rdq_known = 1'b1;
`ifdef LARGE_RAM_CLEAR_ON_RESET_EN
      model_mem.delete();
      cleared = 1'b1;
`endif
    end else if (cs && !we) begin
      if (model_mem.exists(int'(a))) begin
        rdq_m = model_mem[int'(a)]; rdq_known = 1'b1;
      end else if (cleared) begin
        rdq_m = '0; rdq_known = 1'b1;
      end else begin
        rdq_known = 1'b0;
      end
    end else if (cs && we && !oe) begin
      model_mem[int'(a)] = wd;
    end
    e.name = nm;
    e.chk  = drv ? rdq_known : 1'b1;
    e.val  = drv ? rdq_m : tb_data;
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, a, v, "write_bus");
  endtask

  task automatic rd(input logic [AW-1:0] a, input string nm);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, a, '0, nm);
  endtask

  // Monitor: one expectation per cycle, sampled just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          n_chk++;
          if (data === e.val) n_pass++;
          else $display("FAIL %s: data=%h expected=%h at t=%0t", e.name, data, e.val, $time);
        end
      end
    end
  end

  logic [AW-1:0] pool [16];
  initial begin
    pool = '{12'd0, 12'd1, 12'd5, 12'd7, 12'd1022, 12'd1023, 12'd1024, 12'd1025,
             12'd2047, 12'd2048, 12'd3071, 12'd3072, 12'd3073, 12'd4094, 12'd4095, 12'd100};
  end

  initial begin
    logic [DW-1:0] v26 [4];
    logic [AW-1:0] a;
    v26 = '{16'h3524, 16'h5E81, 16'hD609, 16'h5663};

    // Reset with read-like inputs: bus must stay released
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1, 12'd0, '0, "reset_bus_z");

    // Four words near the first bank boundary, read back with one-cycle latency
    for (int i = 0; i < 4; i++) wr(12'(1020 + i), v26[i]);
    for (int i = 0; i < 4; i++) rd(12'(1020 + i), "read_1020_1023");

    // Words either side of every bank boundary stay independent
    for (int i = 0; i < 4; i++) wr(12'(2044 + i), 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) wr(12'(3068 + i), 16'hB000 + 16'(i));
    wr(12'd1023, 16'h1111);
    wr(12'd1024, 16'h2222);
    wr(12'd2048, 16'h3333);
    wr(12'd3072, 16'h4444);
    foreach (pool[i]) rd(pool[i], "bank_boundary_read");
    for (int i = 0; i < 4; i++) rd(12'(2044 + i), "read_2044_2047");
    for (int i = 0; i < 4; i++) rd(12'(3068 + i), "read_3068_3071");

    // Top address and address zero
    wr(12'd0, 16'h0A0A);
    wr(12'd4095, 16'hBEEF);
    rd(12'd4095, "read_top_addr");
    rd(12'd0, "read_addr0");

    // Read immediately after write
    wr(12'd100, 16'hC0DE);
    rd(12'd100, "read_after_write");

    // Deselected write is ignored and bus stays released
    wr(12'd5, 16'h5555);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'd5, 16'h1234, "cs0_write_bus");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'd5, '0, "cs0_read_bus_z");
    rd(12'd5, "cs0_mem_unchanged");

    // Write with output_enable high is ignored
    wr(12'd7, 16'h7777);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'd7, 16'hDEAD, "we_oe_bus");
    rd(12'd7, "we_oe_no_write");

    // Reset in the middle of a read burst
    rd(12'd4095, "pre_reset_read");
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 12'd4095, '0, "mid_reset_bus_z");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 12'd6, 16'h6666, "reset_write_blocked");
    rd(12'd6, "reset_write_read");
    for (int i = 0; i < 4; i++) rd(12'(1020 + i), "post_reset_read");
    rd(12'd4095, "post_reset_top");

    // Randomized traffic over boundary-heavy addresses
    for (int n = 0; n < 1500; n++) begin
      int unsigned op;
      op = $urandom_range(0, 99);
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 15)];
      if (op < 35)       wr(a, DW'($urandom));
      else if (op < 75)  rd(a, "rand_read");
      else if (op < 83)  cycle(1'b0, 1'b1, 1'b0, 1'b0, a, '0, "rand_read_oe0");
      else if (op < 89)  cycle(1'b0, 1'b1, 1'b1, 1'b1, a, DW'($urandom), "rand_we_oe");
      else if (op < 98)  cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), a, DW'($urandom), "rand_deselect");
      else               cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), a, DW'($urandom), "rand_reset");
    end

    // Drain the scoreboard with a bounded wait
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "idle_bus");
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
